// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered priority encoder / arbiter.
// Holds the default width, the index-width helper and the FSM encodings.
package prio_enc_pkg;

    localparam int N_DEF = 8;

    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_HOLD_ENC = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE_ENC,
        S_HOLD = ST_HOLD_ENC
    } state_t;

    // An index bus is never narrower than one bit, even for tiny N.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational downward search with wrap-around: starting at 'start', walk
// towards 0, wrap to N-1, and report the first set bit plus a multi-hit flag.
module prio_find #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic             multi
);

    always_comb begin
        int                pos;
        logic [IDX_W-1:0]  w_p;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        w_p   = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) - k;
            if (pos < 0) pos = pos + N;
            w_p = IDX_W'(pos);
            if (!found && vec[w_p]) begin
                found = 1'b1;
                idx   = w_p;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - {{(N-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority encoder with fixed and round-robin modes and a
// valid/ready output stage that holds its result under backpressure.
module prio_enc_arb
    import prio_enc_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_multi,
    output state_t           dbg_state
);

    // Handshake: a result transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid/out_idx/out_multi are frozen otherwise.
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_multi;
    logic             r_mode;
    logic [IDX_W-1:0] r_ptr;

    logic             w_accept;
    logic             w_load;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_start;
    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic             w_multi;

    assign w_accept = (r_state == S_HOLD) && out_ready;
    assign w_load   = (r_state == S_IDLE) || w_accept;

    // A round-robin result moves the pointer just below the winner when it is
    // taken; a result loaded on that same edge already searches from there.
    assign w_ptr_nxt = (w_accept && r_mode) ?
                       ((r_idx == '0) ? LAST : (r_idx - IDX_W'(1))) : r_ptr;
    assign w_start   = mode ? w_ptr_nxt : LAST;

    prio_find #(.N(N), .IDX_W(IDX_W)) u_find (
        .vec   (req),
        .start (w_start),
        .found (w_found),
        .idx   (w_idx),
        .multi (w_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_multi <= 1'b0;
            r_mode  <= 1'b0;
            r_ptr   <= LAST;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_load) begin
                if (w_found) begin
                    r_state <= S_HOLD;
                    r_idx   <= w_idx;
                    r_multi <= w_multi;
                    r_mode  <= mode;
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign out_valid = (r_state == S_HOLD);
    assign out_idx   = r_idx;
    assign out_multi = r_multi;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb (N=8): a spec-level model checked every
// cycle, plus hand-computed literal expectations along the test plan.
module tb_prio_enc_arb;
    import prio_enc_pkg::*;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         mode = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_multi;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    prio_enc_arb #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_multi (out_multi),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid, m_multi, m_rr;
    int m_idx, m_ptr;

    function automatic int search(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int p;
            p = (start - k + N) % N;
            if (((v >> p) & 8'd1) != 8'd0) return p;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_multi = 0; m_rr = 0; m_idx = 0; m_ptr = N - 1;
        end else begin
            bit taken;
            taken = m_valid && out_ready;
            if (taken && m_rr) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
            if (!m_valid || taken) begin
                if (req == '0) begin
                    m_valid = 0;
                end else begin
                    m_valid = 1;
                    m_idx   = search(req, mode ? m_ptr : N - 1);
                    m_multi = ($countones(req) >= 2);
                    m_rr    = mode;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_valid", 32'(out_valid), 32'(m_valid));
            check("model_idx",   32'(out_idx),   32'(m_idx));
            check("model_multi", 32'(out_multi), 32'(m_multi));
            check("model_state", 32'(dbg_state == S_HOLD), 32'(m_valid));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input bit v, input int idx, input bit multi);
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        check({name, "_idx"},   32'(out_idx),   32'(idx));
        check({name, "_multi"}, 32'(out_multi), 32'(multi));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_queue(input string name, input bit multi);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            expect_out(name, 1, int'(e), multi);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        req = '0; mode = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
        repeat (2) step();
        expect_out("reset", 0, 0, 0);
        rst_n = 1'b1;

        // Fixed priority
        req = 8'b0010_0110; step();
        expect_out("fixed_a", 1, 5, 1);
        req = 8'b0000_0001; step();
        expect_out("fixed_b", 1, 0, 0);

        // Backpressure
        req = 8'b0010_0110; step();
        expect_out("bp_load", 1, 5, 1);
        out_ready = 1'b0; req = 8'h80;
        repeat (4) begin step(); expect_out("bp_hold", 1, 5, 1); end
        out_ready = 1'b1; step();
        expect_out("bp_release", 1, 7, 0);
        req = '0; step();
        expect_out("idle_keep", 0, 7, 0);

        // Round-robin, all requesting
        mode = 1'b1; req = 8'hFF;
        foreach (exp_q[i]) exp_q.delete(i);
        for (int i = 7; i >= 0; i--) exp_q.push_back(W'(i));
        exp_q.push_back(W'(7));
        run_queue("rr_full", 1);

        // Round-robin, sparse, from a fresh pointer
        req = '0;
        reset_pulse();
        req = 8'b1000_0001;
        exp_q.push_back(W'(7)); exp_q.push_back(W'(0));
        exp_q.push_back(W'(7)); exp_q.push_back(W'(0));
        run_queue("rr_sparse", 1);
        req = '0; step();
        expect_out("rr_drain", 0, 0, 1);

        // Mode mix: RR accept of 7 leaves ptr at 6
        req = 8'h80; step();
        expect_out("mix_rr7", 1, 7, 0);
        mode = 1'b0; req = 8'b0100_0100;
        repeat (3) begin step(); expect_out("mix_fixed", 1, 6, 1); end
        mode = 1'b1; step();
        expect_out("mix_rr_a", 1, 6, 1);
        step();
        expect_out("mix_rr_b", 1, 2, 1);

        // Reset in HOLD discards the result and restores ptr
        reset_pulse();
        check("post_reset_valid", 32'(out_valid), 32'd0);
        step();
        expect_out("post_reset", 1, 6, 1);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_enc_arb.md
Name: prio_enc_arb

Overview:
- Parametrised, registered successor to the 3-to-2 combinational priority encoder.
- Takes an N-bit request vector and produces the index of the winning request, a valid flag and a multi-request flag.
- Two modes: fixed priority (highest index wins) and round-robin (rotating priority).
- Output uses a valid/ready handshake so it can feed a pipelined consumer with backpressure.

Parameters:
- N, 8, number of request lines (N >= 2).
- IDX_W, $clog2(N), width of the index output (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request vector, level-sensitive, sampled only at load edges.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled at load edges.
- out_ready  in  1  consumer accepts the current output.
- out_valid  out  1  out_idx/out_multi hold a valid encoding.
- out_idx  out  IDX_W  index of the winning request.
- out_multi  out  1  more than one req bit was set when the result was loaded.

Behaviour:
- Reset (async assert, sync-released by system):
  - out_valid=0, out_idx=0, out_multi=0.
  - Internal priority pointer ptr=N-1.
  - Reset mid-HOLD discards the pending result.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- Load edge: a rising edge where (state==IDLE) or (out_valid && out_ready).
- At a load edge:
  - req != 0: register the encoding and go to or stay in HOLD.
  - req == 0: go to IDLE, clearing out_valid; out_idx and out_multi keep their old values.
- Latency: one cycle from req sampled to out_valid high. Throughput: one result per cycle while out_ready=1 and req != 0.
- HOLD with out_ready=0: out_idx, out_multi and out_valid are frozen. Changes on req or mode are ignored until the next load edge.
- Fixed mode (mode=0): search from index N-1 down to 0; the first set bit wins. ptr is not modified.
- Round-robin mode (mode=1):
  - Search downward starting at ptr, wrapping from 0 to N-1; the first set bit wins.
  - On an accept (out_valid && out_ready) of a result loaded in RR mode with index g, ptr becomes g-1, or N-1 when g==0.
- Simultaneous accept and load: the new encoding uses the post-update ptr, i.e. the combinational next-ptr, not the registered value.
- Mode switch: mode is captured per result, stored internally, and decides whether that result updates ptr on accept. ptr persists across fixed-mode periods.
- out_multi = popcount(req) >= 2 at the load edge.
- out_idx is always < N. There is no X propagation when req==0.

Decomposition:
- Package prio_enc_pkg:
  - default N.
  - function idx_w(n) = max(1, $clog2(n)).
  - localparam encodings for the IDLE and HOLD states.
- One combinational sub-module, prio_find:
  - inputs: vec[N], start[IDX_W].
  - outputs: found, idx[IDX_W], multi.
  - behaviour: downward wrap-around search from start.
- Fixed mode calls prio_find with start=N-1. The top level holds the FSM, ptr and output registers.

Test Plan (N=8):
- Reset: assert rst_n=0 asynchronously between clock edges -> out_valid=0, out_idx=0, out_multi=0 immediately; ptr=7 after release.
- Fixed mode: mode=0, out_ready=1, req=8'b0010_0110 -> one cycle later out_valid=1, out_idx=5, out_multi=1. Then req=8'b0000_0001 -> out_idx=0, out_multi=0.
- Backpressure: in HOLD with out_idx=5, out_ready=0 for 4 cycles while req changes to 8'h80 -> out_idx stays 5. On the cycle out_ready=1 -> next cycle out_idx=7.
- Round-robin full: mode=1, req=8'hFF held, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, out_multi=1 throughout.
- Round-robin sparse: mode=1, req=8'b1000_0001 held, out_ready=1 -> out_idx 7,0,7,0. Then req=0 -> out_valid=0 after the next accept edge.
- Mode mix and reset mid-HOLD:
  - RR: accept idx 7 (ptr=6).
  - mode=0 with req=8'b0100_0100 -> out_idx 6 repeatedly; ptr stays 6.
  - mode=1 -> out_idx 6 then 2.
  - Assert rst_n in HOLD -> out_valid drops at once; after release, with mode=1 held and req=8'b0100_0100, the first result is 6 (ptr back to 7).
